nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_add_ctrl_slice.sv | 31 +++
 rtl/nibble_serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width
// and the operand-width legality rule.
package nibble_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Operand width must be whole nibbles and at least two passes long.
  function automatic bit width_legal(input int w);
    return (w % NIB_W == 0) && (w >= 8) && (w <= 64);
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3,
// which the controller needs for two's-complement overflow on the top nibble.
module cla_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: one CLA slice reused over WIDTH/4 passes.
// Define NIBBLE_SERIAL_ADD_CTRL_SUB_EN to add the sub port (A - B).
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: illegal WIDTH %0d", WIDTH);
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE, so a result
  // handshake and a new acceptance can never share an edge.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [3:0]         slice_s;
  logic               slice_co, slice_c3;
  logic               last_pass;

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last_pass = (idx_q == IDX_W'(NIB - 1));

  cla_nibble_slice u_slice (
    .a  (a_q[idx_q*NIB_W +: NIB_W]),
    .b  (b_q[idx_q*NIB_W +: NIB_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_pass) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // The carry register is seeded with the operation's carry-in at acceptance,
  // so the first RUN pass needs no special case.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b_eff;
        carry_d = cin_eff;
        idx_d   = '0;
      end
      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_pass) begin
          cout_d = slice_co;
          ovf_d  = slice_c3 ^ slice_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (WIDTH=16): directed corner cases plus
// random operations, checked against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Each entry: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, tb,
                                         input logic tc, ts);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic         ov;
    bb   = ts ? ~tb : tb;
    cc   = ts ? 1'b1 : tc;
    full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
    ov   = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b1;  // must not be accepted while in reset
    a        = W'($urandom);
    b        = W'($urandom);
    repeat (cycles) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_idle", in_ready, 1);
  endtask

  task automatic accept_op(input logic [W-1:0] ta, tb, input logic tc, ts);
    int cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    @(negedge clk);
    check("accept_busy", in_ready, 0);
    exp_q.push_back(model(ta, tb, tc, ts));
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(input bit noise);
    int cyc = 0;
    while (!out_valid && cyc < 4 * NIB + 8) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (!out_valid) check("run_in_ready", in_ready, 0);
    end
    in_valid = noise ? 1'b0 : in_valid;
    check("latency", cyc, NIB);
  endtask

  task automatic drain(input int stall, input bit noise, input bit keep_in);
    logic [W+1:0] e = '0;
    check("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    check("sum", sum, e[W-1:0]);
    check("cout", cout, e[W]);
    check("ovf", ovf, e[W+1]);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
      end
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_sum", sum, e[W-1:0]);
      check("stall_cout", cout, e[W]);
      check("stall_ovf", ovf, e[W+1]);
    end
    if (!keep_in) in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  task automatic full_op(input logic [W-1:0] ta, tb, input logic tc, ts,
                         input int stall, input bit noise);
    accept_op(ta, tb, tc, ts);
    wait_done(noise);
    drain(stall, noise, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    do_reset(2);

    full_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    full_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    full_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    // Backpressure with in_valid noise during RUN and DONE
    full_op(16'h8000, 16'h8000, 1'b0, 1'b0, 3, 1'b1);

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    full_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    full_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 1'b0);
`endif

    // Reset mid-RUN at idx==2: partial result discarded
    accept_op(16'hABCD, 16'h1111, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    do_reset(1);
    full_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    // Reset while in DONE
    accept_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_done(1'b0);
    do_reset(1);

    // Back-to-back: second set held on in_valid through DONE
    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    a = 16'h7000; b = 16'h1000; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    wait_done(1'b0);
    drain(2, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_accept", in_ready, 0);
    exp_q.push_back(model(16'h7000, 16'h1000, 1'b1, 1'b0));
    in_valid = 1'b0;
    wait_done(1'b0);
    drain(0, 1'b0, 1'b0);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      full_op(ra, rb, rc, rs, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
